// File: rtl/xnor_gate_sweep_ctrl_if.sv
// rtl/xnor_gate_sweep_ctrl_if.sv - host/gate bundle for the XNOR gate sweep controller
interface xnor_gate_sweep_ctrl_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            abort;
    logic            dut_y;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] fail_vec;
    logic            fail_valid;

    modport master (
        output start, abort, dut_y,
        input  dut_in, busy, done, pass, err_cnt, fail_vec, fail_valid
    );

    modport slave (
        input  start, abort, dut_y,
        output dut_in, busy, done, pass, err_cnt, fail_vec, fail_valid
    );
endinterface

// File: rtl/xnor_gate_sweep_ctrl.sv
// rtl/xnor_gate_sweep_ctrl.sv - exhaustive input sweep and checker for an N-input XNOR gate
module xnor_gate_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xnor_gate_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] ALL_ONES = '1;
    localparam logic [3:0]      CNT_INIT = 4'(SETTLE - 1);

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [N_IN-1:0] dut_in_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   err_cnt_q;
    logic [N_IN-1:0] fail_vec_q;
    logic            fail_valid_q;

    logic            mismatch_d;
    logic [N_IN:0]   err_cnt_d;

    // Only meaningful on a sample edge; dut_y is a combinational function of dut_in_q.
    always_comb begin
        mismatch_d = (bus.dut_y != ~^dut_in_q);
        err_cnt_d  = err_cnt_q + {{N_IN{1'b0}}, mismatch_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dut_in_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state_q      <= S_HOLD;
                        dut_in_q     <= '0;
                        cnt_q        <= CNT_INIT;
                        busy_q       <= 1'b1;
                        err_cnt_q    <= '0;
                        fail_vec_q   <= '0;
                        fail_valid_q <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (bus.abort) begin
                        // Partial err_cnt/fail_* are kept for post-mortem; this edge is not sampled.
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        dut_in_q <= '0;
                        pass_q   <= 1'b0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        err_cnt_q <= err_cnt_d;
                        if (mismatch_d && !fail_valid_q) begin
                            fail_vec_q   <= dut_in_q;
                            fail_valid_q <= 1'b1;
                        end
                        if (dut_in_q != ALL_ONES) begin
                            dut_in_q <= dut_in_q + 1'b1;
                            cnt_q    <= CNT_INIT;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                        end
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    done_q   <= 1'b0;
                    dut_in_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.fail_vec   = fail_vec_q;
    assign bus.fail_valid = fail_valid_q;
endmodule
